// File: rtl/fifo_param.sv
// fifo_param: parameterised single-clock FIFO with fill count, almost flags and sticky error flags.
// Latency: registered read data one cycle after an accepted read (FWFT build: head visible combinationally).
// Backpressure: writes to a full FIFO are rejected unless a read is accepted in the same cycle; reads on empty are rejected.
//
// Build option: define FIFO_FWFT_EN for first-word-fall-through output behaviour.
//
// Ports:
//   clk            clock, all state updates on rising edge
//   reset          asynchronous active-low reset
//   data_in        write data, captured when en_write is accepted
//   en_write       write request
//   en_read        read request
//   err_clr        clears sticky overflow/underflow (a new error in the same cycle wins)
//   data_out       read data
//   full / empty   count == DEPTH / count == 0
//   almost_full    count >= AFULL_THRESH
//   almost_empty   count <= AEMPTY_THRESH
//   count          occupancy 0..DEPTH
//   overflow       sticky: a write was rejected
//   underflow      sticky: a read was rejected
module fifo_param #(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = 14,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_WIDTH-1:0]     data_in,
   input  logic                      en_write,
   input  logic                      en_read,
   input  logic                      err_clr,
   output logic [DATA_WIDTH-1:0]     data_out,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  rd_acc;
   logic                  wr_acc;

   // Flags come straight from the registered count.
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AFULL_C);
   assign almost_empty = (count <= AEMPTY_C);

   // A full FIFO can still take a write when a read frees a slot in the same cycle.
   // A read on empty is never accepted, even alongside a write.
   assign rd_acc = en_read & ~empty;
   assign wr_acc = en_write & (~full | rd_acc);

   // Storage is deliberately not reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         dout_q    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
         if (wr_acc) begin
            wptr <= wptr + ADDR_WIDTH'(1);
         end
         if (rd_acc) begin
            rptr   <= rptr + ADDR_WIDTH'(1);
            dout_q <= mem[rptr];
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Set has priority over clear.
         if (en_write & ~wr_acc) begin
            overflow <= 1'b1;
         end else if (err_clr) begin
            overflow <= 1'b0;
         end
         if (en_read & empty) begin
            underflow <= 1'b1;
         end else if (err_clr) begin
            underflow <= 1'b0;
         end
      end
   end

`ifdef FIFO_FWFT_EN
   // Head word falls through while data is present; once empty, the last popped word is held.
   assign data_out = empty ? dout_q : mem[rptr];
`else
   assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] data_in;
   logic          en_write;
   logic          en_read;
   logic          err_clr;
   logic [DW-1:0] data_out;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   fifo_param #(
      .DATA_WIDTH   (DW),
      .DEPTH        (DEPTH),
      .AFULL_THRESH (AF),
      .AEMPTY_THRESH(AE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .data_in     (data_in),
      .en_write    (en_write),
      .en_read     (en_read),
      .err_clr     (err_clr),
      .data_out    (data_out),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   // Reference model: a queue holding the FIFO contents plus the last popped word.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_last;
   bit            m_ovf;
   bit            m_unf;
   int            n_chk  = 0;
   int            n_pass = 0;

   typedef struct {
      bit            wr;
      bit            rd;
      bit            clr;
      logic [DW-1:0] din;
      int            cnt;
      logic [DW-1:0] dout;
      bit            emp;
      bit            ovf;
      bit            unf;
   } vec_t;

   vec_t tbl[10];

   function automatic logic [DW-1:0] m_dout();
`ifdef FIFO_FWFT_EN
      if (mq.size() > 0) return mq[0];
`endif
      return m_last;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      m_last = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   task automatic chk_all(input string tag);
      int sz;
      sz = mq.size();
      chk({tag, ".count"},        32'(count),        32'(sz));
      chk({tag, ".full"},         32'(full),         32'(sz == DEPTH));
      chk({tag, ".empty"},        32'(empty),        32'(sz == 0));
      chk({tag, ".almost_full"},  32'(almost_full),  32'(sz >= AF));
      chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
      chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
      chk({tag, ".underflow"},    32'(underflow),    32'(m_unf));
      chk({tag, ".data_out"},     32'(data_out),     32'(m_dout()));
   endtask

   // One clock of stimulus; model advanced from pre-edge state, outputs checked 1ns after the edge.
   task automatic step(input bit wr, input bit rd, input bit clr, input logic [DW-1:0] din, input string tag);
      int sz;
      bit rd_ok, wr_ok;
      en_write = wr;
      en_read  = rd;
      err_clr  = clr;
      data_in  = din;
      sz    = mq.size();
      rd_ok = rd && (sz > 0);
      wr_ok = wr && ((sz < DEPTH) || rd_ok);
      @(posedge clk);
      #1;
      m_ovf = (wr && !wr_ok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = (rd && sz == 0) ? 1'b1 : (clr ? 1'b0 : m_unf);
      if (rd_ok) m_last = mq.pop_front();
      if (wr_ok) mq.push_back(din);
      en_write = 1'b0;
      en_read  = 1'b0;
      err_clr  = 1'b0;
      chk_all(tag);
   endtask

   initial begin
      //            wr rd clr din    cnt dout   emp ovf unf
      tbl[0] = '{1, 0, 0, 8'h01, 1, 8'h00, 0, 0, 0};
      tbl[1] = '{1, 0, 0, 8'h02, 2, 8'h00, 0, 0, 0};
      tbl[2] = '{0, 1, 0, 8'h00, 1, 8'h01, 0, 0, 0};
      tbl[3] = '{1, 1, 0, 8'h03, 1, 8'h02, 0, 0, 0};
      tbl[4] = '{0, 1, 0, 8'h00, 0, 8'h03, 1, 0, 0};
      tbl[5] = '{0, 1, 0, 8'h00, 0, 8'h03, 1, 0, 1};
      tbl[6] = '{1, 1, 0, 8'h04, 1, 8'h03, 0, 0, 1};
      tbl[7] = '{0, 0, 1, 8'h00, 1, 8'h03, 0, 0, 0};
      tbl[8] = '{0, 1, 1, 8'h00, 0, 8'h04, 1, 0, 0};
      tbl[9] = '{0, 1, 1, 8'h00, 0, 8'h04, 1, 0, 1};

      reset    = 1'b0;
      en_write = 1'b0;
      en_read  = 1'b0;
      err_clr  = 1'b0;
      data_in  = '0;
      model_reset();

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst.count",        32'(count),        32'd0);
      chk("rst.empty",        32'(empty),        32'd1);
      chk("rst.almost_empty", 32'(almost_empty), 32'd1);
      chk("rst.full",         32'(full),         32'd0);
      chk("rst.almost_full",  32'(almost_full),  32'd0);
      chk("rst.overflow",     32'(overflow),     32'd0);
      chk("rst.underflow",    32'(underflow),    32'd0);
      chk("rst.data_out",     32'(data_out),     32'd0);
      reset = 1'b1;

      // Hand-derived vectors: small occupancy, empty-side rejects, clear priority
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.cnt", i), 32'(count),     32'(tbl[i].cnt));
         chk($sformatf("tbl%0d.emp", i), 32'(empty),     32'(tbl[i].emp));
         chk($sformatf("tbl%0d.ovf", i), 32'(overflow),  32'(tbl[i].ovf));
         chk($sformatf("tbl%0d.unf", i), 32'(underflow), 32'(tbl[i].unf));
`ifndef FIFO_FWFT_EN
         chk($sformatf("tbl%0d.dout", i), 32'(data_out), 32'(tbl[i].dout));
`endif
      end
      step(0, 0, 1, 8'h00, "clr0");

      // Fill 0x10..0x1F, then a rejected 17th write
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 0, 8'(8'h10 + i), $sformatf("fill%0d", i));
         chk($sformatf("fill%0d.cnt", i), 32'(count), 32'(i + 1));
      end
      chk("fill.full", 32'(full), 32'd1);
      step(1, 0, 0, 8'hAA, "ovf");
      chk("ovf.flag",  32'(overflow), 32'd1);
      chk("ovf.count", 32'(count),    32'd16);

      // Drain, then a read on empty
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 0, 8'h00, $sformatf("drain%0d", i));
`ifndef FIFO_FWFT_EN
         chk($sformatf("drain%0d.dout", i), 32'(data_out), 32'(8'h10 + i));
`endif
      end
      chk("drain.empty", 32'(empty), 32'd1);
      step(0, 1, 0, 8'h00, "unf");
      chk("unf.flag", 32'(underflow), 32'd1);
      chk("unf.dout", 32'(data_out),  32'h1F);

      // Simultaneous read+write at empty, at count 8, and at full
      step(1, 1, 0, 8'h30, "rw_empty");
      chk("rw_empty.count", 32'(count), 32'd1);
      for (int i = 1; i < 8; i++) step(1, 0, 0, 8'(8'h30 + i), "to8");
      step(1, 1, 0, 8'h38, "rw_8");
      chk("rw_8.count", 32'(count), 32'd8);
      while (mq.size() < DEPTH) step(1, 0, 0, 8'($urandom), "to16");
      step(0, 0, 1, 8'h00, "clr1");
      step(1, 1, 0, 8'h77, "rw_full");
      chk("rw_full.count", 32'(count),    32'd16);
      chk("rw_full.ovf",   32'(overflow), 32'd0);

      // Randomised traffic with varying read/write bias to exercise wrap, full and empty
      for (int p = 0; p < 4; p++) begin
         int wp;
         wp = (p == 0) ? 80 : (p == 1) ? 20 : (p == 2) ? 50 : 65;
         for (int i = 0; i < 60; i++) begin
            step($urandom_range(99) < wp, $urandom_range(99) < (100 - wp) + 10,
                 $urandom_range(99) < 5, 8'($urandom), $sformatf("rnd%0d_%0d", p, i));
         end
      end

      // Error clear, then clear racing a new underflow
      step(0, 0, 1, 8'h00, "errclr");
      chk("errclr.ovf", 32'(overflow),  32'd0);
      chk("errclr.unf", 32'(underflow), 32'd0);
      while (mq.size() > 0) step(0, 1, 0, 8'h00, "flush");
      step(0, 1, 1, 8'h00, "clr_vs_unf");
      chk("clr_vs_unf.unf", 32'(underflow), 32'd1);

      // Asynchronous reset between edges at count 5
      for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h60 + i), "pre_ar");
      chk("pre_ar.count", 32'(count), 32'd5);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk_all("areset");
      chk("areset.empty", 32'(empty), 32'd1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      step(1, 0, 0, 8'h55, "post_w");
      step(0, 1, 0, 8'h00, "post_r");
      chk("post_r.dout", 32'(data_out), 32'h55);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
